// File: rtl/orb_pkg.sv
// Shared definitions for the orbit frame RAM write path.
package orb_pkg;

   localparam int unsigned ORB_ADDR_W = 10;
   localparam int unsigned ORB_DATA_W = 12;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      WRITE   = 2'd2,
      RELEASE = 2'd3
   } orb_state_t;

   // Slots with addr[1:0]==0 belong to the designated owner; the digital
   // writer uses the same rule.
   function automatic logic is_resv_slot(input logic [ORB_ADDR_W-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/orb_write_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or above rr_ptr, wrapping.
module rr_pick #(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      rr_ptr,
   output logic [1:0]      winner,
   output logic            valid
);

   // Scan offsets from rr_ptr; the first requester hit wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         for (int unsigned j = 0; j < NREQ; j++) begin
            if (!valid && req[j] && (((32'(rr_ptr) + i) % NREQ) == j)) begin
               valid  = 1'b1;
               winner = 2'(j);
            end
         end
      end
   end

endmodule

// File: rtl/orb_write_arbiter.sv
// Round-robin arbiter for the orbit frame RAM write port with slot-ownership
// enforcement and a setup / write-enable / hold sequence per transaction.
module orb_write_arbiter
   import orb_pkg::*;
#(
   parameter int unsigned NREQ        = 2,
   parameter int unsigned ADDR_W      = ORB_ADDR_W,
   parameter int unsigned DATA_W      = ORB_DATA_W,
   parameter int unsigned WREN_CYCLES = 2,
   parameter int unsigned RESV_REQ    = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*ADDR_W-1:0]   reqAddr,
   input  logic [NREQ*DATA_W-1:0]   reqWord,
   output logic [NREQ-1:0]          ack,
   output logic [NREQ-1:0]          nack,
   output logic [DATA_W-1:0]        orbWord,
   output logic [ADDR_W-1:0]        orbAddr,
   output logic                     orbWren,
   output logic                     busy,
   output logic [1:0]               grantId,
   output logic                     violation
);

   orb_state_t state, state_nx;
   logic [1:0] rr_ptr;
   logic [2:0] wren_cnt;
   logic       refused;
   logic [1:0] pick_id;
   logic       pick_valid;
   logic       grant_load;
   logic       own_bad;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .winner (pick_id),
      .valid  (pick_valid)
   );

   assign own_bad = is_resv_slot(ORB_ADDR_W'(orbAddr[1:0])) != (grantId == 2'(RESV_REQ));

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state decode and per-state outputs.
   always_comb begin
      state_nx   = state;
      grant_load = 1'b0;
      orbWren    = 1'b0;
      ack        = '0;
      nack       = '0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (pick_valid) begin
               grant_load = 1'b1;
               state_nx   = SETUP;
            end
         end
         SETUP: begin
            state_nx = own_bad ? RELEASE : WRITE;
         end
         WRITE: begin
            orbWren = 1'b1;
            if (wren_cnt == 3'(WREN_CYCLES - 1)) state_nx = RELEASE;
         end
         RELEASE: begin
            for (int unsigned j = 0; j < NREQ; j++) begin
               if (grantId == 2'(j)) begin
                  ack[j]  = !refused;
                  nack[j] = refused;
               end
            end
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Grant latch, pointer, write counter and ownership flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         orbAddr   <= '0;
         orbWord   <= '0;
         grantId   <= '0;
         rr_ptr    <= '0;
         wren_cnt  <= '0;
         refused   <= 1'b0;
         violation <= 1'b0;
      end else begin
         if (grant_load) begin
            orbAddr <= reqAddr[pick_id*ADDR_W +: ADDR_W];
            orbWord <= reqWord[pick_id*DATA_W +: DATA_W];
            grantId <= pick_id;
            rr_ptr  <= 2'((32'(pick_id) + 1) % NREQ);
         end
         if (state == SETUP) begin
            refused <= own_bad;
            if (own_bad) violation <= 1'b1;
         end
         if (state == WRITE) wren_cnt <= wren_cnt + 3'd1;
         else                wren_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_orb_write_arbiter.sv
// Randomized bench for orb_write_arbiter against a transaction-level schedule model.
module tb_orb_write_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 12;
   localparam int unsigned WC = 2;
   localparam int unsigned RV = 0;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req;
   logic [N*AW-1:0] reqAddr;
   logic [N*DW-1:0] reqWord;
   logic [N-1:0]  ack, nack;
   logic [DW-1:0] orbWord;
   logic [AW-1:0] orbAddr;
   logic          orbWren, busy, violation;
   logic [1:0]    grantId;

   orb_write_arbiter #(
      .NREQ(N), .ADDR_W(AW), .DATA_W(DW), .WREN_CYCLES(WC), .RESV_REQ(RV)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .reqAddr(reqAddr), .reqWord(reqWord),
      .ack(ack), .nack(nack), .orbWord(orbWord), .orbAddr(orbAddr),
      .orbWren(orbWren), .busy(busy), .grantId(grantId), .violation(violation)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          busy;
      logic          wren;
      logic [N-1:0]  ackv;
      logic [N-1:0]  nackv;
      logic [AW-1:0] addr;
      logic [DW-1:0] word;
      logic [1:0]    grant;
      logic          set_viol;
   } exp_t;

   exp_t q[$];
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // Expected-state of the model
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_word;
   logic [1:0]    last_grant;
   logic          m_viol;
   int unsigned   m_rr;
   logic [N-1:0]  inflight;
   logic [AW-1:0] drv_addr [N];
   logic [DW-1:0] drv_word [N];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      last_addr  = '0;
      last_word  = '0;
      last_grant = '0;
      m_viol     = 1'b0;
      m_rr       = 0;
      inflight   = '0;
   endtask

   function automatic logic [AW-1:0] pick_addr(input int unsigned who);
      logic [AW-1:0] a;
      a = AW'($urandom);
      if ($urandom_range(0, 4) != 0) begin
         if (who == RV) a[1:0] = 2'b00;
         else if (a[1:0] == 2'b00) a[1:0] = 2'(1 + $urandom_range(0, 2));
      end
      if ($urandom_range(0, 15) == 0) a = '1;
      return a;
   endfunction

   // Schedule the whole transaction once the winner is known.
   task automatic schedule(input int unsigned w);
      exp_t e;
      logic bad;
      bad = (drv_addr[w][1:0] == 2'b00) != (w == RV);
      e.busy = 1'b1; e.wren = 1'b0; e.ackv = '0; e.nackv = '0;
      e.addr = drv_addr[w]; e.word = drv_word[w]; e.grant = 2'(w); e.set_viol = 1'b0;
      q.push_back(e);
      if (!bad) begin
         e.wren = 1'b1;
         for (int unsigned k = 0; k < WC; k++) q.push_back(e);
         e.wren = 1'b0;
         e.ackv = N'(1) << w;
      end else begin
         e.nackv    = N'(1) << w;
         e.set_viol = 1'b1;
      end
      q.push_back(e);
   endtask

   initial begin
      exp_t e;
      logic cur_idle, prev_wren, rst_pending;
      reset = 1'b0;
      req = '0;
      reqAddr = '0;
      reqWord = '0;
      model_reset();
      prev_wren = 1'b0;
      rst_pending = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wren", 32'(orbWren), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_nack", 32'(nack), 32'd0);
      check("rst_addr", 32'(orbAddr), 32'd0);
      check("rst_word", 32'(orbWord), 32'd0);
      check("rst_grant", 32'(grantId), 32'd0);
      check("rst_viol", 32'(violation), 32'd0);
      reset = 1'b1;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (rst_pending) begin
            reset = 1'b1;
            rst_pending = 1'b0;
         end
         cur_idle = (q.size() == 0);
         if (!cur_idle) begin
            e = q.pop_front();
            last_addr  = e.addr;
            last_word  = e.word;
            last_grant = e.grant;
            if (e.set_viol) m_viol = 1'b1;
         end else begin
            e.busy = 1'b0; e.wren = 1'b0; e.ackv = '0; e.nackv = '0;
            e.addr = last_addr; e.word = last_word; e.grant = last_grant; e.set_viol = 1'b0;
         end

         check("busy", 32'(busy), 32'(e.busy));
         check("wren", 32'(orbWren), 32'(e.wren));
         check("ack", 32'(ack), 32'(e.ackv));
         check("nack", 32'(nack), 32'(e.nackv));
         check("addr", 32'(orbAddr), 32'(e.addr));
         check("word", 32'(orbWord), 32'(e.word));
         check("grant", 32'(grantId), 32'(e.grant));
         check("viol", 32'(violation), 32'(m_viol));

         // Requester reaction to its completion pulse
         for (int unsigned i = 0; i < N; i++) begin
            if (e.ackv[i] || e.nackv[i]) begin
               req[i] = 1'b0;
               inflight[i] = 1'b0;
            end
         end

         // Granted requester may scribble its inputs or give up early
         for (int unsigned i = 0; i < N; i++) begin
            if (inflight[i] && req[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  reqAddr[i*AW +: AW] = AW'($urandom);
                  reqWord[i*DW +: DW] = DW'($urandom);
               end
               if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
            end
         end

         // Reset landing on the edge that ends the first write-enable cycle
         if (e.wren && !prev_wren && $urandom_range(0, 7) == 0) begin
            reset = 1'b0;
            rst_pending = 1'b1;
            req = '0;
            model_reset();
            prev_wren = 1'b0;
            continue;
         end
         prev_wren = e.wren;

         for (int unsigned i = 0; i < N; i++) begin
            if (!inflight[i] && !req[i] && $urandom_range(0, 9) < 3) begin
               drv_addr[i] = pick_addr(i);
               drv_word[i] = DW'($urandom);
               reqAddr[i*AW +: AW] = drv_addr[i];
               reqWord[i*DW +: DW] = drv_word[i];
               req[i] = 1'b1;
            end
         end

         if (cur_idle && req != '0) begin
            for (int unsigned k = 0; k < N; k++) begin
               int unsigned w;
               w = (m_rr + k) % N;
               if (req[w]) begin
                  schedule(w);
                  inflight[w] = 1'b1;
                  m_rr = (w + 1) % N;
                  break;
               end
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
